// File: rtl/integer_emitter_if.sv
// Character-stream handshake bundle between the attribute writer and integer_emitter.
`ifndef CHAR_BITES
`define CHAR_BITES 8
`endif
`ifndef ATTRIBUTE_VAL_BITES
`define ATTRIBUTE_VAL_BITES 10
`endif

interface integer_emitter_if #(
  parameter int WIDTH = `ATTRIBUTE_VAL_BITES
);
  logic                   start;
  logic [WIDTH-1:0]       value;
  logic [`CHAR_BITES-1:0] term;
  logic [`CHAR_BITES-1:0] char;
  logic                   char_valid;
  logic                   char_ready;
  logic                   busy;
  logic                   has_finished;

  modport slave (
    input  start, value, term, char_ready,
    output char, char_valid, busy, has_finished
  );

  modport master (
    output start, value, term, char_ready,
    input  char, char_valid, busy, has_finished
  );
endinterface

// File: rtl/integer_emitter.sv
// Binary -> ASCII decimal emitter: sequential double-dabble, then one char per handshake.
// Build option: INTEGER_EMITTER_ZERO_PAD_EN emits all MAX_DIGITS digits (no zero suppression).
`ifndef CHAR_BITES
`define CHAR_BITES 8
`endif
`ifndef ATTRIBUTE_VAL_BITES
`define ATTRIBUTE_VAL_BITES 10
`endif

module integer_emitter #(
  parameter int WIDTH      = `ATTRIBUTE_VAL_BITES,
  parameter int MAX_DIGITS = 4
) (
  input  logic            clock,
  input  logic            reset,
  integer_emitter_if.slave bus
);

  localparam int BW = 4 * MAX_DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_EMIT,
    S_TERM,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [WIDTH-1:0]       bin_q;
  logic [WIDTH-1:0]       bin_d;
  logic [BW-1:0]          bcd_q;
  logic [BW-1:0]          bcd_adj;
  logic [BW-1:0]          bcd_d;
  logic [CW-1:0]          cnt_q;
  logic [IW-1:0]          idx_q;
  logic [IW-1:0]          idx_m1;
  logic [IW-1:0]          first_idx_d;
  logic [`CHAR_BITES-1:0] term_q;
  logic [`CHAR_BITES-1:0] char_q;
  logic [`CHAR_BITES-1:0] cur_char;
  logic [`CHAR_BITES-1:0] next_char;
  logic                   valid_q;
  logic                   busy_q;
  logic                   fin_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
    bin_d = {bin_q[WIDTH-2:0], 1'b0};

    // Looks at the post-shift BCD so the index is ready on the final convert edge.
    first_idx_d = '0;
`ifdef INTEGER_EMITTER_ZERO_PAD_EN
    first_idx_d = IW'(MAX_DIGITS - 1);
`else
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (bcd_d[4*i +: 4] != 4'd0) first_idx_d = IW'(i);
    end
`endif

    idx_m1    = IW'(idx_q - 1'b1);
    cur_char  = `CHAR_BITES'(8'h30) + `CHAR_BITES'(bcd_q[{idx_q, 2'b00} +: 4]);
    next_char = `CHAR_BITES'(8'h30) + `CHAR_BITES'(bcd_q[{idx_m1, 2'b00} +: 4]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      term_q  <= '0;
      char_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            bin_q   <= bus.value;
            term_q  <= bus.term;
            bcd_q   <= '0;
            cnt_q   <= CW'(WIDTH - 1);
            fin_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            idx_q   <= first_idx_d;
            state_q <= S_EMIT;
          end
        end
        S_EMIT: begin
          // First EMIT cycle only loads the leading digit; afterwards each accept advances.
          if (!valid_q) begin
            char_q  <= cur_char;
            valid_q <= 1'b1;
          end else if (bus.char_ready) begin
            if (idx_q == '0) begin
              if (term_q != '0) begin
                char_q  <= term_q;
                state_q <= S_TERM;
              end else begin
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                fin_q   <= 1'b1;
                state_q <= S_DONE;
              end
            end else begin
              idx_q  <= idx_m1;
              char_q <= next_char;
            end
          end
        end
        S_TERM: begin
          if (bus.char_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.char         = char_q;
  assign bus.char_valid   = valid_q;
  assign bus.busy         = busy_q;
  assign bus.has_finished = fin_q;

endmodule

// File: tb/tb_integer_emitter.sv
// Bench for integer_emitter: decimal-string reference model, directed cases plus random traffic.
`timescale 1ns/1ps
module tb_integer_emitter;
  localparam int WIDTH = 10;
  localparam int MAXD  = 4;

  typedef logic [7:0] ch_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  integer_emitter_if #(.WIDTH(WIDTH)) bus ();

  integer_emitter #(.WIDTH(WIDTH), .MAX_DIGITS(MAXD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int    checks = 0;
  int    errors = 0;
  ch_t   exp_q[$];
  string log_s = "";
  int    ready_mode = 0;  // 0 manual, 1 always, 2 toggle, 3 random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  // Reference: decimal text of v (optionally zero padded), then terminator if nonzero.
  function automatic int build(input int unsigned v, input ch_t t);
    ch_t d[$];
    int unsigned x = v;
    do begin
      d.push_front(ch_t'(8'h30 + (x % 10)));
      x = x / 10;
    end while (x != 0);
`ifdef INTEGER_EMITTER_ZERO_PAD_EN
    while (d.size() < MAXD) d.push_front(ch_t'(8'h30));
`endif
    foreach (d[i]) exp_q.push_back(d[i]);
    if (t != 8'h00) exp_q.push_back(t);
    return exp_q.size();
  endfunction

  initial begin
    bus.char_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (ready_mode)
        1: bus.char_ready = 1'b1;
        2: bus.char_ready = ~bus.char_ready;
        3: bus.char_ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  // Compare process: every valid char must be the model's next char; pop on handshake.
  initial begin
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && bus.char_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_char: got %0h expected no valid char at %0t", bus.char, $time);
        end else begin
          chk("char", 32'(bus.char), 32'(exp_q[0]));
          if (bus.char_ready === 1'b1) begin
            log_s = $sformatf("%s%c", log_s, bus.char);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic run(input int unsigned v, input ch_t t, input int mode, input bit inject);
    int nchars;
    int lat;
    int n;
    nchars = build(v, t);
    log_s = "";
    ready_mode = mode;
    @(posedge clock);
    #2;
    bus.start = 1'b1;
    bus.value = WIDTH'(v);
    bus.term  = t;
    @(posedge clock);
    #2;
    bus.start = 1'b0;
    @(negedge clock);
    chk("fin_cleared", 32'(bus.has_finished), 32'd0);
    chk("busy_set", 32'(bus.busy), 32'd1);
    lat = 0;
    while (bus.char_valid !== 1'b1 && lat < 50) begin
      @(negedge clock);
      lat++;
      if (inject && lat == 3) begin
        bus.start = 1'b1;
        bus.value = WIDTH'(5);
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("latency", 32'(lat), 32'(WIDTH + 1));
    n = 0;
    while (bus.has_finished !== 1'b1 && n < 300) begin
      chk("busy_during", 32'(bus.busy), 32'd1);
      @(negedge clock);
      n++;
    end
    chk("finish_timeout", 32'(n < 300), 32'd1);
    if (mode == 1) chk("b2b_cycles", 32'(n), 32'(nchars));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("busy_done", 32'(bus.busy), 32'd0);
    chk("valid_done", 32'(bus.char_valid), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int lat;
    bus.start = 1'b0;
    bus.value = '0;
    bus.term  = '0;
    #13;
    chk("rst_char", 32'(bus.char), 32'd0);
    chk("rst_valid", 32'(bus.char_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_fin", 32'(bus.has_finished), 32'd0);
    @(negedge clock);
    reset = 1'b1;

`ifdef INTEGER_EMITTER_ZERO_PAD_EN
    run(0, " ", 1, 0);     chk_str("s_zero", log_s, "0000 ");
    run(1023, ">", 1, 0);  chk_str("s_1023", log_s, "1023>");
    run(407, 8'h00, 2, 0); chk_str("s_407", log_s, "0407");
    run(42, 8'h00, 1, 1);  chk_str("s_42", log_s, "0042");
    run(5, 8'h00, 1, 0);   chk_str("s_5", log_s, "0005");
    run(7, " ", 1, 0);     chk_str("s_7", log_s, "0007 ");
`else
    run(0, " ", 1, 0);     chk_str("s_zero", log_s, "0 ");
    run(1023, ">", 1, 0);  chk_str("s_1023", log_s, "1023>");
    run(407, 8'h00, 2, 0); chk_str("s_407", log_s, "407");
    run(42, 8'h00, 1, 1);  chk_str("s_42", log_s, "42");
    run(5, 8'h00, 1, 0);   chk_str("s_5", log_s, "5");
    run(7, " ", 1, 0);     chk_str("s_7", log_s, "7 ");
`endif

    // Abort mid-emission: accept the first char of 123, then async reset.
    void'(build(123, 8'h00));
    log_s = "";
    ready_mode = 0;
    bus.char_ready = 1'b0;
    @(posedge clock);
    #2;
    bus.start = 1'b1;
    bus.value = WIDTH'(123);
    bus.term  = 8'h00;
    @(posedge clock);
    #2;
    bus.start = 1'b0;
    lat = 0;
    while (bus.char_valid !== 1'b1 && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    chk("rst_test_valid", 32'(bus.char_valid), 32'd1);
    @(posedge clock);
    #2;
    bus.char_ready = 1'b1;
    @(posedge clock);
    #2;
    bus.char_ready = 1'b0;
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_valid", 32'(bus.char_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_fin", 32'(bus.has_finished), 32'd0);
`ifdef INTEGER_EMITTER_ZERO_PAD_EN
    chk_str("s_abort", log_s, "0");
`else
    chk_str("s_abort", log_s, "1");
`endif
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    run(9, 8'h00, 1, 0);
`ifdef INTEGER_EMITTER_ZERO_PAD_EN
    chk_str("s_9", log_s, "0009");
`else
    chk_str("s_9", log_s, "9");
`endif

    for (int i = 0; i < 40; i++) begin
      int unsigned v;
      ch_t t;
      v = $urandom_range(0, 1023);
      case ($urandom_range(0, 3))
        0: t = 8'h00;
        1: t = " ";
        2: t = ">";
        default: t = ch_t'($urandom_range(33, 126));
      endcase
      run(v, t, $urandom_range(1, 3), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/integer_emitter.md
Name: integer_emitter

Overview:
- Serializes an unsigned binary attribute value into a stream of ASCII decimal characters, most-significant digit first, optionally followed by a terminator character.
- Inverse of the attribute integer parser; used by the tag/attribute writer to render numeric attributes into the character stream.
- Binary-to-BCD conversion uses sequential double-dabble, then a valid/ready character handshake per digit.

Parameters:
- WIDTH, 10, bit width of the input value. Matches `ATTRIBUTE_VAL_BITES.
- MAX_DIGITS, 4, number of BCD digits held. Must satisfy 10^MAX_DIGITS > 2^WIDTH - 1, so no overflow can occur.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  pulse; requests conversion of value. Sampled only in IDLE or DONE.
- value  input  WIDTH  unsigned value to emit. Latched on an accepted start.
- term  input  `CHAR_BITES  terminator character, e.g. " " or ">". Latched on an accepted start. 8'h00 means no terminator.
- char  output  `CHAR_BITES  current output character.
- char_valid  output  1  char holds a valid character.
- char_ready  input  1  consumer accepts char this cycle.
- busy  output  1  conversion or emission in progress.
- has_finished  output  1  stream complete. Held until the next accepted start.

Behaviour:
- Reset (async, reset==0):
  - state=IDLE.
  - char=0, char_valid=0, busy=0, has_finished=0.
  - Internal BCD, shift and digit registers cleared.
  - A reset in any state aborts immediately. No further characters are emitted.
- States: IDLE, CONVERT, EMIT, TERM, DONE.
- IDLE/DONE + start=1 (accepted start):
  - Latch value and term.
  - Clear BCD and has_finished; set busy=1; go to CONVERT.
  - start is ignored in all other states.
- CONVERT (exactly WIDTH cycles):
  - Each cycle, add 3 to every BCD nibble >=5, then shift {bcd, bin} left by 1.
  - Counter runs WIDTH-1 down to 0.
  - On the last cycle, compute the index of the first nonzero digit. If the value is 0, the index is the least-significant digit. Then go to EMIT.
- Latency: char_valid first rises on the clock edge WIDTH+1 edges after the edge that sampled start (11 cycles at the default WIDTH).
- EMIT:
  - char = 8'h30 + current BCD digit; char_valid=1.
  - Leading zeros are suppressed. Value 0 emits a single "0".
  - char and char_valid stay stable until char_ready=1.
  - On a cycle with char_valid && char_ready: advance to the next lower digit. Back-to-back acceptance gives one character per cycle.
  - After the least-significant digit is accepted: go to TERM if latched term != 0, else DONE.
- TERM:
  - char = latched term; char_valid=1.
  - Go to DONE when char_ready=1.
- DONE:
  - char_valid=0, busy=0, has_finished=1.
  - has_finished stays 1 until the next accepted start.
  - start in DONE behaves as in IDLE, and has_finished falls on the edge that accepts it.
- char_ready while char_valid=0 is ignored.

Optional Feature:
- Macro: INTEGER_EMITTER_ZERO_PAD_EN.
- Defined: leading-zero suppression is disabled. Exactly MAX_DIGITS digits are always emitted (e.g. 42 → "0042"; 0 → "0000").
- Undefined: minimal-length decimal, as described in Behaviour.

Test Plan:
- value=0, term=" ", char_ready=1 → chars "0", " ". has_finished rises 1 cycle after " " is accepted. First char_valid is 11 cycles after start.
- value=1023, term=">", char_ready=1 → "1","0","2","3",">" on consecutive cycles. busy=1 throughout. has_finished=1 after.
- value=407, term=8'h00, char_ready toggling 0/1 every cycle → "4","0","7". Each char is held stable while char_ready=0. No terminator. Embedded zero is not suppressed.
- start pulsed during CONVERT with a new value=5 → ignored; the original value=42 emits "4","2". Second start in DONE emits "5" and clears has_finished.
- reset asserted mid-EMIT of 123 after "1" was accepted → char_valid=0, busy=0, has_finished=0 immediately (asynchronously). Next start with 9 emits "9".
- With INTEGER_EMITTER_ZERO_PAD_EN, value=7, term=" " → "0","0","0","7"," ".
